imem_loader: RTL and testbench

Write-side companion to the instruction memory: receives a byte stream from a host link and writes whole 32-bit instruction words into the instruction memory's write port. It runs before the processor starts fetching and holds the core off while loading. It replaces the file-based preload for silicon and FPGA bring-up.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader session states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes assembled into one instruction word.
  localparam int BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: collects four stream bytes and
// presents the completed word in the same cycle the fourth byte is accepted.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Byte counter and partial-word register; both stay put while i_valid is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    // NOTE: this is a tiny datapath register, not a memory, so it is cleared
    // on reset; discarding a partial word on reset relies on that.
    if (!rst_n || i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      // Newest byte enters at the top; after three bytes byte 0 sits in [7:0].
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  // The fourth byte completes the word directly from the input, so the FSM
  // can register it on the same edge that accepts that byte.
  assign o_word_valid = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_shift};

endmodule : imem_loader_byte_packer

// File: rtl/imem_loader.sv
// Streams host bytes into the instruction memory as 32-bit words while
// holding the core off via busy.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  state_t              r_state;
  logic                r_s_ready;
  logic                r_im_we;
  logic [ADDR_W-1:0]   r_im_waddr;
  logic [31:0]         r_im_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [31:0]         r_checksum;
  logic [ADDR_W:0]     r_word_cnt;
  logic [ADDR_W:0]     r_len;

  logic                w_start_acc;
  logic                w_byte_acc;
  logic                w_len_zero;
  logic                w_len_too_big;
  logic [ADDR_W:0]     w_cnt_next;
  logic                w_word_valid;
  logic [31:0]         w_word;

  // Start is honoured only between sessions; len is sampled on that edge only.
  assign w_start_acc   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_byte_acc    = s_valid && r_s_ready;
  assign w_len_zero    = (len == '0);
  assign w_len_too_big = (32'(len) > 32'(DEPTH));
  assign w_cnt_next    = r_word_cnt + 1'b1;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start_acc),
    .i_valid      (w_byte_acc),
    .i_byte       (s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Session FSM with registered outputs, word counter and running checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_s_ready  <= 1'b0;
      r_im_we    <= 1'b0;
      r_im_waddr <= '0;
      r_im_wdata <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_checksum <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_acc) begin
            r_word_cnt <= '0;
            r_checksum <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            if (w_len_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (w_len_too_big) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state   <= RECV;
              r_len     <= len[ADDR_W:0];
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        RECV: begin
          if (w_word_valid) begin
            r_state    <= WRITE;
            r_s_ready  <= 1'b0;
            r_im_we    <= 1'b1;
            r_im_waddr <= r_word_cnt[ADDR_W-1:0];
            r_im_wdata <= w_word;
          end
        end
        WRITE: begin
          r_im_we    <= 1'b0;
          r_checksum <= r_checksum ^ r_im_wdata;
          r_word_cnt <= w_cnt_next;
          if (w_cnt_next == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= RECV;
            r_s_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign im_we    = r_im_we;
  assign im_waddr = r_im_waddr;
  assign im_wdata = r_im_wdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign checksum = r_checksum;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       checksum;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  int                n_cmp = 0;
  int                n_mis = 0;
  logic [31:0]       model_csum;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic              prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && im_we === 1'b1) begin
      check("we_back_to_back", {31'd0, prev_we}, 32'd0);
      check("s_ready_in_write", {31'd0, s_ready}, 32'd0);
      check("busy_in_write", {31'd0, busy}, 32'd1);
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $error("FAIL unexpected_write: observed addr %0d data 0x%08h expected no write",
               im_waddr, im_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("waddr", {22'd0, im_waddr}, {22'd0, e.addr});
        check("wdata", im_wdata, e.data);
      end
      last_waddr = im_waddr;
    end
    prev_we = im_we;
  end

  // All driver tasks are entered and left just after a falling edge.
  task automatic pulse_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 16'hBEEF;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int n   = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!acc) begin
      acc = s_ready;
      @(negedge clk);
      n++;
      if (!acc && n > 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        acc = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_data  = 8'hXX;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input bit gap);
    wr_t e;
    e.addr = a;
    e.data = w;
    sb.push_back(e);
    model_csum = model_csum ^ w;
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_waddr", {22'd0, im_waddr}, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    len     = '0;
    s_data  = '0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load from the reference byte stream.
    model_csum = '0;
    pulse_start(16'd2);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("s_ready_after_start", {31'd0, s_ready}, 32'd1);
    send_word(10'd0, 32'h0000_0013, 1'b0);
    send_word(10'd1, 32'h0010_0093, 1'b0);
    wait_done(20);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_checksum", checksum, 32'h0010_0080);
    check("t1_model_checksum", checksum, model_csum);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_sb_empty", sb.size(), 32'd0);

    // Three words with a bubble after every byte.
    model_csum = '0;
    pulse_start(16'd3);
    send_word(10'd0, 32'hDEAD_BEEF, 1'b1);
    send_word(10'd1, 32'h1234_5678, 1'b1);
    send_word(10'd2, 32'hA5C3_0F96, 1'b1);
    wait_done(20);
    check("t2_err", {31'd0, err}, 32'd0);
    check("t2_checksum", checksum, model_csum);
    check("t2_sb_empty", sb.size(), 32'd0);

    // Zero-length and oversize requests finish immediately without writes.
    pulse_start(16'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_err", {31'd0, err}, 32'd0);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_checksum", checksum, 32'd0);
    pulse_start(16'd1025);
    check("len1025_done", {31'd0, done}, 32'd1);
    check("len1025_err", {31'd0, err}, 32'd1);
    check("len1025_s_ready", {31'd0, s_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("len1025_err_held", {31'd0, err}, 32'd1);

    // Full-depth load at full rate.
    model_csum = '0;
    pulse_start(16'd1024);
    for (int i = 0; i < DEPTH; i++)
      send_word(ADDR_W'(i), (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5, 1'b0);
    wait_done(20);
    check("full_last_addr", {22'd0, last_waddr}, 32'd1023);
    check("full_err", {31'd0, err}, 32'd0);
    check("full_checksum", checksum, model_csum);
    check("full_sb_empty", sb.size(), 32'd0);

    // Reset in the middle of the second word of a four-word session.
    model_csum = '0;
    pulse_start(16'd4);
    send_word(10'd0, 32'h1111_2222, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_sb_empty", sb.size(), 32'd0);
    check("midrst_idle_ready", {31'd0, s_ready}, 32'd0);
    model_csum = '0;
    pulse_start(16'd1);
    send_word(10'd0, 32'hCAFE_F00D, 1'b0);
    wait_done(20);
    check("postrst_checksum", checksum, 32'hCAFE_F00D);
    check("postrst_sb_empty", sb.size(), 32'd0);

    // A start pulse mid-session must be ignored.
    model_csum = '0;
    pulse_start(16'd2);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    pulse_start(16'd5);
    begin
      wr_t e;
      e.addr = 10'd0;
      e.data = 32'h1234_5678;
      sb.push_back(e);
      model_csum = 32'h1234_5678;
    end
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_word(10'd1, 32'h0BAD_F00D, 1'b0);
    wait_done(20);
    check("midstart_err", {31'd0, err}, 32'd0);
    check("midstart_checksum", checksum, model_csum);
    check("midstart_sb_empty", sb.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_imem_loader
